riscv_wb_arbiter: RTL and testbench

- Write-back stage directly upstream of the integer/FP register file's second write port (W2).
- Merges result streams from the multi-cycle units (LSU, MULT/DIV, FPU) into one registered write per cycle.
- Round-robin arbitration with valid/ready handshakes.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards against in-flight multi-cycle results.

---
 rtl/riscv_wb_arbiter.sv | 118 +++++++++++
 tb/tb_riscv_wb_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter: write-back merge for register-file port W2.
// Round-robin arbitration over the multi-cycle result sources (LSU, MULT/DIV, FPU),
// one registered write per cycle, and a pending-write scoreboard for decode RAW stalls.
// Optional feature macro: DIFT_WB_TAG_EN (adds src_wtag_i / wtag_o and the tag flops).
module riscv_wb_arbiter #(
  parameter int N_SRC      = 3,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 1,
  parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_SRC-1:0]                      src_valid_i,
  output logic [N_SRC-1:0]                      src_ready_o,
  input  logic [N_SRC-1:0][ADDR_WIDTH-1:0]      src_waddr_i,
  input  logic [N_SRC-1:0][DATA_WIDTH-1:0]      src_wdata_i,
`ifdef DIFT_WB_TAG_EN
  input  logic [N_SRC-1:0][TAG_WIDTH-1:0]       src_wtag_i,
  output logic [TAG_WIDTH-1:0]                  wtag_o,
`endif
  input  logic                                  alloc_valid_i,
  input  logic [ADDR_WIDTH-1:0]                 alloc_addr_i,
  output logic [ADDR_WIDTH-1:0]                 waddr_o,
  output logic [DATA_WIDTH-1:0]                 wdata_o,
  output logic                                  we_o,
  output logic [NUM_REGS-1:0]                   pending_o
);

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  // Elaboration-time sanity checks on the configuration.
  if (TAG_WIDTH < 1) begin : g_bad_tag_width
    $error("riscv_wb_arbiter: TAG_WIDTH must be >= 1");
  end
  if (N_SRC < 1) begin : g_bad_n_src
    $error("riscv_wb_arbiter: N_SRC must be >= 1");
  end

  logic [PW-1:0]       ptr;
  logic [PW-1:0]       gnt_idx;
  logic                gnt_any;
  logic [N_SRC-1:0]    grant;
  logic [PW-1:0]       ptr_nxt;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  // Round-robin pick: first valid source at or after ptr, wrapping past N_SRC-1.
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    idx     = 0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!gnt_any && src_valid_i[idx]) begin
        gnt_any    = 1'b1;
        gnt_idx    = PW'(idx);
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

  // Ready is forced low while reset is held so no source believes it was accepted.
  assign src_ready_o = rst_n ? grant : '0;

  // Next pointer is one past the winner; a wrap is explicit since N_SRC need not be a power of two.
  assign ptr_nxt = (gnt_idx == PW'(N_SRC - 1)) ? '0 : gnt_idx + PW'(1);

  // Pointer advances only on a grant.
  always_ff @(posedge clk) begin
    if (!rst_n)       ptr <= '0;
    else if (gnt_any) ptr <= ptr_nxt;
  end

  // Output stage: drains every cycle; a write to x0 is accepted but never enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else if (gnt_any) begin
      we_o    <= |src_waddr_i[gnt_idx];
      waddr_o <= src_waddr_i[gnt_idx];
      wdata_o <= src_wdata_i[gnt_idx];
    end else begin
      we_o    <= 1'b0;
    end
  end

`ifdef DIFT_WB_TAG_EN
  // Tag travels with the data, same load condition and reset value.
  always_ff @(posedge clk) begin
    if (!rst_n)       wtag_o <= '0;
    else if (gnt_any) wtag_o <= src_wtag_i[gnt_idx];
  end
`endif

  // Scoreboard next state: clear on the write edge, then set so a younger alloc wins; x0 never pends.
  always_comb begin
    pending_nxt = pending;
    if (we_o)          pending_nxt[waddr_o]      = 1'b0;
    if (alloc_valid_i) pending_nxt[alloc_addr_i] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign pending_o = pending;

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Directed self-checking bench for riscv_wb_arbiter.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_riscv_wb_arbiter;
  localparam int N_SRC = 3;
  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int TW    = 1;
  localparam int NR    = 2**AW;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [N_SRC-1:0]         src_valid;
  logic [N_SRC-1:0]         src_ready;
  logic [N_SRC-1:0][AW-1:0] src_waddr;
  logic [N_SRC-1:0][DW-1:0] src_wdata;
`ifdef DIFT_WB_TAG_EN
  logic [N_SRC-1:0][TW-1:0] src_wtag;
  logic [TW-1:0]            wtag;
`endif
  logic                     alloc_valid;
  logic [AW-1:0]            alloc_addr;
  logic [AW-1:0]            waddr;
  logic [DW-1:0]            wdata;
  logic                     we;
  logic [NR-1:0]            pending;

  int tests = 0;
  int fails = 0;

  riscv_wb_arbiter #(.N_SRC(N_SRC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid_i(src_valid), .src_ready_o(src_ready),
    .src_waddr_i(src_waddr), .src_wdata_i(src_wdata),
`ifdef DIFT_WB_TAG_EN
    .src_wtag_i(src_wtag), .wtag_o(wtag),
`endif
    .alloc_valid_i(alloc_valid), .alloc_addr_i(alloc_addr),
    .waddr_o(waddr), .wdata_o(wdata), .we_o(we), .pending_o(pending)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    src_valid   = '0;
    alloc_valid = 1'b0;
    alloc_addr  = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    src_valid = 3'b111;
    src_waddr[0] = 6'd1; src_waddr[1] = 6'd2; src_waddr[2] = 6'd3;
    src_wdata[0] = 32'h10; src_wdata[1] = 32'h20; src_wdata[2] = 32'h30;
    alloc_valid = 1'b1; alloc_addr = 6'd4;
    #1;
    tests++; if (src_ready !== 3'b000) begin fails++; $display("FAIL reset_ready got=%b exp=000", src_ready); end
    tick();
    tick();
    tests++; if (we !== 1'b0) begin fails++; $display("FAIL reset_we got=%b exp=0", we); end
    tests++; if (pending !== '0) begin fails++; $display("FAIL reset_pending got=%h exp=0", pending); end
    tests++; if (waddr !== 6'd0 || wdata !== 32'd0) begin fails++; $display("FAIL reset_data got=%0d/%h exp=0/0", waddr, wdata); end
    rst_n = 1'b1;
    alloc_valid = 1'b0;
    #1;
    tests++; if (src_ready !== 3'b001) begin fails++; $display("FAIL reset_first_grant got=%b exp=001", src_ready); end
    tick();
    src_valid = '0;
    tests++; if (we !== 1'b1 || waddr !== 6'd1) begin fails++; $display("FAIL reset_first_write got we=%b addr=%0d exp we=1 addr=1", we, waddr); end
  endtask

  task automatic test_single;
    do_reset();
    alloc_valid = 1'b1; alloc_addr = 6'd7;          // cycle 0
    tick();                                         // cycle 1
    alloc_valid = 1'b0;
    tests++; if (pending[7] !== 1'b1) begin fails++; $display("FAIL single_pend_c1 got=%b exp=1", pending[7]); end
    tick();                                         // cycle 2
    tests++; if (pending[7] !== 1'b1) begin fails++; $display("FAIL single_pend_c2 got=%b exp=1", pending[7]); end
    tick();                                         // cycle 3
    src_valid = 3'b010; src_waddr[1] = 6'd7; src_wdata[1] = 32'hDEADBEEF;
    #1;
    tests++; if (src_ready !== 3'b010) begin fails++; $display("FAIL single_ready got=%b exp=010", src_ready); end
    tests++; if (pending[7] !== 1'b1) begin fails++; $display("FAIL single_pend_c3 got=%b exp=1", pending[7]); end
    tick();                                         // cycle 4
    src_valid = '0;
    tests++; if (we !== 1'b1 || waddr !== 6'd7) begin fails++; $display("FAIL single_write got we=%b addr=%0d exp we=1 addr=7", we, waddr); end
    tests++; if (wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL single_data got=%h exp=deadbeef", wdata); end
    tests++; if (pending[7] !== 1'b1) begin fails++; $display("FAIL single_pend_c4 got=%b exp=1", pending[7]); end
    tick();                                         // cycle 5
    tests++; if (pending[7] !== 1'b0) begin fails++; $display("FAIL single_pend_c5 got=%b exp=0", pending[7]); end
    tests++; if (we !== 1'b0) begin fails++; $display("FAIL single_we_drop got=%b exp=0", we); end
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_rdy [4];
    logic [5:0] exp_addr [4];
    exp_rdy  = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_addr = '{6'd1, 6'd2, 6'd3, 6'd1};
    do_reset();
    src_valid = 3'b111;
    src_waddr[0] = 6'd1; src_waddr[1] = 6'd2; src_waddr[2] = 6'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (src_ready !== exp_rdy[i]) begin fails++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, src_ready, exp_rdy[i]); end
      tick();
      if (i == 3) src_valid = '0;
      tests++; if (we !== 1'b1 || waddr !== exp_addr[i]) begin fails++; $display("FAIL rr_write[%0d] got we=%b addr=%0d exp we=1 addr=%0d", i, we, waddr, exp_addr[i]); end
    end
  endtask

  task automatic test_collision;
    do_reset();
    alloc_valid = 1'b1; alloc_addr = 6'd9;
    tick();
    alloc_valid = 1'b0;
    src_valid = 3'b001; src_waddr[0] = 6'd9; src_wdata[0] = 32'h99;
    #1;
    tests++; if (src_ready !== 3'b001) begin fails++; $display("FAIL coll_ready got=%b exp=001", src_ready); end
    tick();
    src_valid = '0;
    alloc_valid = 1'b1; alloc_addr = 6'd9;
    tests++; if (we !== 1'b1 || waddr !== 6'd9) begin fails++; $display("FAIL coll_write got we=%b addr=%0d exp we=1 addr=9", we, waddr); end
    tick();
    alloc_valid = 1'b0;
    tests++; if (pending[9] !== 1'b1) begin fails++; $display("FAIL coll_set_wins got=%b exp=1", pending[9]); end
    // Second result for 9 with no new alloc now clears it.
    src_valid = 3'b001;
    tick();
    src_valid = '0;
    tick();
    tests++; if (pending[9] !== 1'b0) begin fails++; $display("FAIL coll_clear got=%b exp=0", pending[9]); end
  endtask

  task automatic test_addr0;
    do_reset();
    src_valid = 3'b100; src_waddr[2] = 6'd0; src_wdata[2] = 32'h5;
    #1;
    tests++; if (src_ready !== 3'b100) begin fails++; $display("FAIL a0_ready got=%b exp=100", src_ready); end
    tick();
    src_valid = '0;
    tests++; if (we !== 1'b0) begin fails++; $display("FAIL a0_we got=%b exp=0", we); end
    alloc_valid = 1'b1; alloc_addr = 6'd0;
    tick();
    alloc_valid = 1'b0;
    tests++; if (pending !== '0) begin fails++; $display("FAIL a0_pending got=%h exp=0", pending); end
  endtask

  task automatic test_bypass_hold;
    do_reset();
    src_valid = 3'b010; src_waddr[1] = 6'd12; src_wdata[1] = 32'h1234;
    tick();
    src_valid = '0;
    tests++; if (we !== 1'b1 || waddr !== 6'd12) begin fails++; $display("FAIL byp_write got we=%b addr=%0d exp we=1 addr=12", we, waddr); end
    tests++; if (pending !== '0) begin fails++; $display("FAIL byp_pending got=%h exp=0", pending); end
    tick();
    tests++; if (we !== 1'b0) begin fails++; $display("FAIL hold_we got=%b exp=0", we); end
    tests++; if (waddr !== 6'd12 || wdata !== 32'h1234) begin fails++; $display("FAIL hold_data got=%0d/%h exp=12/1234", waddr, wdata); end
    // Pointer sat at 2 through the idle cycle.
    src_valid = 3'b111;
    src_waddr[0] = 6'd1; src_waddr[2] = 6'd3;
    #1;
    tests++; if (src_ready !== 3'b100) begin fails++; $display("FAIL hold_ptr got=%b exp=100", src_ready); end
    tick();
    src_valid = '0;
    tests++; if (we !== 1'b1 || waddr !== 6'd3) begin fails++; $display("FAIL hold_ptr_write got we=%b addr=%0d exp we=1 addr=3", we, waddr); end
  endtask

  task automatic test_mid_reset;
    do_reset();
    alloc_valid = 1'b1; alloc_addr = 6'd5;
    src_valid = 3'b010; src_waddr[1] = 6'd20; src_wdata[1] = 32'hCAFE;
    tick();
    idle();
    tests++; if (we !== 1'b1 || pending[5] !== 1'b1) begin fails++; $display("FAIL mid_pre got we=%b p5=%b exp 1/1", we, pending[5]); end
    rst_n = 1'b0;
    src_valid = 3'b010;
    #1;
    tests++; if (src_ready !== 3'b000) begin fails++; $display("FAIL mid_ready got=%b exp=000", src_ready); end
    tick();
    src_valid = '0;
    tests++; if (we !== 1'b0 || waddr !== 6'd0 || wdata !== 32'd0) begin fails++; $display("FAIL mid_out got we=%b addr=%0d data=%h exp 0/0/0", we, waddr, wdata); end
    tests++; if (pending !== '0) begin fails++; $display("FAIL mid_pending got=%h exp=0", pending); end
    rst_n = 1'b1;
  endtask

`ifdef DIFT_WB_TAG_EN
  task automatic test_tag;
    do_reset();
    src_wtag = '0;
    src_valid = 3'b001; src_waddr[0] = 6'd33; src_wdata[0] = 32'hF00D; src_wtag[0] = 1'b1;
    tick();
    src_valid = '0;
    tests++; if (we !== 1'b1 || waddr !== 6'd33 || wtag !== 1'b1) begin fails++; $display("FAIL tag_write got we=%b addr=%0d tag=%b exp 1/33/1", we, waddr, wtag); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    idle();
    src_waddr = '0;
    src_wdata = '0;
`ifdef DIFT_WB_TAG_EN
    src_wtag = '0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_collision();
    test_addr0();
    test_bypass_hold();
    test_mid_reset();
`ifdef DIFT_WB_TAG_EN
    test_tag();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
